stack_seq_arbiter: RTL and testbench

Controller in front of stack_unit that shares the single 8-bit stack between two requesters: port 0 for CPU PUSH/POP and port 1 for interrupt entry/exit frames.
- Accepts 1- or 2-byte transactions and sequences them into per-byte push/pop strobes.
- Pre-checks stack capacity so every transaction is atomic: it either completes fully or touches nothing.
- Returns popped data and a completion/error handshake to the winning requester.

---
 rtl/stack_seq_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_stack_seq_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq_arbiter.sv
// Two-port sequencer that shares one 8-bit stack between CPU and interrupt frames.
// Optional STACK_SEQ_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
module stack_seq_arbiter #(
  parameter logic [7:0] STACK_LIMIT = 8'd8,
  parameter logic       PRIO_PORT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        op0,
  input  logic [1:0]  len0,
  input  logic [15:0] wdata0,
  output logic        done0,
  output logic        err0,
  input  logic        req1,
  input  logic        op1,
  input  logic [1:0]  len1,
  input  logic [15:0] wdata1,
  output logic        done1,
  output logic        err1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        grant_id,
  input  logic [7:0]  stack_pointer,
  input  logic [7:0]  stack_base,
  output logic        stk_push_en,
  output logic        stk_pop_en,
  output logic [7:0]  stk_push_data,
  input  logic [7:0]  stk_pop_data,
  input  logic        stk_valid
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    PUSH      = 3'd2,
    POP_ISSUE = 3'd3,
    POP_WAIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        lat_op, lat_op_nxt;
  logic [1:0]  lat_len, lat_len_nxt;
  logic [15:0] lat_wdata, lat_wdata_nxt;
  logic        byte_idx, byte_idx_nxt;
  logic        wait_cnt, wait_cnt_nxt;
  logic        busy_nxt, grant_nxt, push_en_nxt, pop_en_nxt;
  logic [7:0]  push_data_nxt;
  logic [15:0] rdata_nxt;
  logic        fin, fin_err, winner;
  logic [8:0]  push_floor, pop_top;

  assign push_floor = {1'b0, STACK_LIMIT} + {7'd0, lat_len};
  assign pop_top    = {1'b0, stack_pointer} + {7'd0, lat_len};

`ifdef STACK_SEQ_ROUND_ROBIN_EN
  logic last_served, last_served_nxt;

  // Remember the last granted port so ties alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= 1'b0;
    end else begin
      last_served <= last_served_nxt;
    end
  end

  // Tie goes to the port not served last.
  always_comb begin
    if (req0 && req1) begin
      winner = ~last_served;
    end else begin
      winner = req1;
    end
  end
`else
  // Tie goes to the fixed priority port.
  always_comb begin
    if (req0 && req1) begin
      winner = PRIO_PORT;
    end else begin
      winner = req1;
    end
  end
`endif

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_nxt     = state;
    lat_op_nxt    = lat_op;
    lat_len_nxt   = lat_len;
    lat_wdata_nxt = lat_wdata;
    byte_idx_nxt  = byte_idx;
    wait_cnt_nxt  = wait_cnt;
    busy_nxt      = busy;
    grant_nxt     = grant_id;
    push_en_nxt   = 1'b0;
    pop_en_nxt    = 1'b0;
    push_data_nxt = stk_push_data;
    rdata_nxt     = rdata;
    fin           = 1'b0;
    fin_err       = 1'b0;
`ifdef STACK_SEQ_ROUND_ROBIN_EN
    last_served_nxt = last_served;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt     = CHECK;
          grant_nxt     = winner;
          busy_nxt      = 1'b1;
          rdata_nxt     = 16'd0;
          lat_op_nxt    = winner ? op1 : op0;
          lat_len_nxt   = winner ? len1 : len0;
          lat_wdata_nxt = winner ? wdata1 : wdata0;
          byte_idx_nxt  = 1'b0;
          wait_cnt_nxt  = 1'b0;
`ifdef STACK_SEQ_ROUND_ROBIN_EN
          last_served_nxt = winner;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        // Capacity is checked up front so a transaction never partially executes.
        if (lat_len == 2'd3) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (lat_len == 2'd0) begin
          fin = 1'b1;
        end else if (!lat_op) begin
          if ({1'b0, stack_pointer} >= push_floor) begin
            state_nxt     = PUSH;
            push_en_nxt   = 1'b1;
            push_data_nxt = (lat_len == 2'd2) ? lat_wdata[15:8] : lat_wdata[7:0];
          end else begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end else begin
          if (pop_top <= {1'b0, stack_base}) begin
            state_nxt  = POP_ISSUE;
            pop_en_nxt = 1'b1;
          end else begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
      end
      PUSH: begin
        if (!byte_idx && (lat_len == 2'd2)) begin
          byte_idx_nxt  = 1'b1;
          push_en_nxt   = 1'b1;
          push_data_nxt = lat_wdata[7:0];
        end else begin
          fin = 1'b1;
        end
      end
      POP_ISSUE: begin
        state_nxt    = POP_WAIT;
        wait_cnt_nxt = 1'b0;
      end
      POP_WAIT: begin
        if (stk_valid) begin
          if (byte_idx) begin
            rdata_nxt[15:8] = stk_pop_data;
          end else begin
            rdata_nxt[7:0] = stk_pop_data;
          end
          if (!byte_idx && (lat_len == 2'd2)) begin
            byte_idx_nxt = 1'b1;
            state_nxt    = POP_ISSUE;
            pop_en_nxt   = 1'b1;
          end else begin
            fin = 1'b1;
          end
        end else if (wait_cnt) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          wait_cnt_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
    state_nxt = fin ? DONE : state_nxt;
  end

  // State, transaction latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_op        <= 1'b0;
      lat_len       <= 2'd0;
      lat_wdata     <= 16'd0;
      byte_idx      <= 1'b0;
      wait_cnt      <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= 1'b0;
      stk_push_en   <= 1'b0;
      stk_pop_en    <= 1'b0;
      stk_push_data <= 8'd0;
      rdata         <= 16'd0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
    end else begin
      state         <= state_nxt;
      lat_op        <= lat_op_nxt;
      lat_len       <= lat_len_nxt;
      lat_wdata     <= lat_wdata_nxt;
      byte_idx      <= byte_idx_nxt;
      wait_cnt      <= wait_cnt_nxt;
      busy          <= busy_nxt;
      grant_id      <= grant_nxt;
      stk_push_en   <= push_en_nxt;
      stk_pop_en    <= pop_en_nxt;
      stk_push_data <= push_data_nxt;
      rdata         <= rdata_nxt;
      done0         <= fin & ~grant_id;
      done1         <= fin & grant_id;
      err0          <= fin & fin_err & ~grant_id;
      err1          <= fin & fin_err & grant_id;
    end
  end

endmodule

// File: tb/tb_stack_seq_arbiter.sv
// Scoreboard bench for stack_seq_arbiter with a behavioural stack_unit model.
module tb_stack_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, op0, req1, op1;
  logic [1:0]  len0, len1;
  logic [15:0] wdata0, wdata1;
  logic        done0, err0, done1, err1;
  logic [15:0] rdata;
  logic        busy, grant_id;
  logic [7:0]  sp, base;
  logic        stk_push_en, stk_pop_en, stk_valid;
  logic [7:0]  stk_push_data, stk_pop_data;
  logic        sp_load;
  logic [7:0]  sp_load_val;
  logic [7:0]  mem [0:255];

  typedef struct {
    logic        port;
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_push[$];
  int         exp_pops = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  stack_seq_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .len0(len0), .wdata0(wdata0), .done0(done0), .err0(err0),
    .req1(req1), .op1(op1), .len1(len1), .wdata1(wdata1), .done1(done1), .err1(err1),
    .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .stack_pointer(sp), .stack_base(base),
    .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en), .stk_push_data(stk_push_data),
    .stk_pop_data(stk_pop_data), .stk_valid(stk_valid)
  );

  // Descending stack model: push writes below SP, pop reads at SP with one-cycle valid.
  always @(posedge clk) begin
    stk_valid <= 1'b0;
    if (sp_load) begin
      sp <= sp_load_val;
    end else if (stk_push_en) begin
      mem[sp - 8'd1] <= stk_push_data;
      sp <= sp - 8'd1;
    end else if (stk_pop_en) begin
      stk_pop_data <= mem[sp];
      sp <= sp + 8'd1;
      stk_valid <= 1'b1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_txn(input logic p, input logic e, input logic [15:0] rd, input int lat);
    exp_t x;
    x.port = p; x.err = e; x.rdata = rd; x.lat = lat;
    sb.push_back(x);
  endfunction

  task automatic monitor();
    logic busy_q;
    int   cyc, grant_cyc;
    exp_t e;
    busy_q = 1'b0; cyc = 0; grant_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy_q = 1'b0;
      end else begin
        if (busy && !busy_q) grant_cyc = cyc - 1;
        busy_q = busy;
        if (stk_push_en || stk_pop_en) chk("strobe_excl", {31'd0, stk_push_en & stk_pop_en}, 32'd0);
        if (stk_push_en) begin
          chk("push_expected", {31'd0, exp_push.size() != 0}, 32'd1);
          if (exp_push.size() != 0) chk("push_byte", {24'd0, stk_push_data}, {24'd0, exp_push.pop_front()});
        end
        if (stk_pop_en) begin
          chk("pop_expected", {31'd0, exp_pops != 0}, 32'd1);
          if (exp_pops != 0) exp_pops--;
        end
        if (done0 || done1) begin
          chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done_port", {30'd0, done1, done0}, e.port ? 32'd2 : 32'd1);
            chk("err_bits", {30'd0, err1, err0}, e.port ? {30'd0, e.err, 1'b0} : {31'd0, e.err});
            chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
            chk("latency", cyc - grant_cyc, e.lat);
          end
        end
      end
    end
  endtask

  task automatic drive(input logic p, input logic op, input logic [1:0] len, input logic [15:0] wd);
    logic seen;
    seen = 1'b0;
    if (p) begin
      op1 = op; len1 = len; wdata1 = wd; req1 = 1'b1;
    end else begin
      op0 = op; len0 = len; wdata0 = wd; req0 = 1'b1;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = p ? done1 : done0;
    end
    chk(p ? "done1_timeout" : "done0_timeout", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic set_sp(input logic [7:0] v);
    @(posedge clk); #1;
    sp_load = 1'b1; sp_load_val = v;
    @(posedge clk); #1;
    sp_load = 1'b0;
  endtask

  function automatic logic [7:0] tie_data(input logic p);
    return p ? 8'h22 : 8'h11;
  endfunction

  initial begin
    logic w;
    logic seen;
    rst = 1'b1; base = 8'h48; sp_load = 1'b0; sp_load_val = 8'h00;
    req0 = 1'b0; op0 = 1'b0; len0 = 2'd0; wdata0 = 16'd0;
    req1 = 1'b0; op1 = 1'b0; len1 = 2'd0; wdata1 = 16'd0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {done0, err0, done1, err1, busy, grant_id, stk_push_en, stk_pop_en,
        stk_push_data, rdata}, 32'd0);
    rst = 1'b0;
    set_sp(8'h48);

    expect_txn(1'b1, 1'b0, 16'h0000, 4);
    exp_push.push_back(8'hBE); exp_push.push_back(8'hEF);
    drive(1'b1, 1'b0, 2'd2, 16'hBEEF);
    chk("sp_after_push2", {24'd0, sp}, 32'h46);

    expect_txn(1'b0, 1'b0, 16'hBEEF, 6);
    exp_pops += 2;
    drive(1'b0, 1'b1, 2'd2, 16'h0000);
    chk("sp_after_pop2", {24'd0, sp}, 32'h48);

    expect_txn(1'b0, 1'b1, 16'h0000, 2);
    drive(1'b0, 1'b1, 2'd1, 16'h0000);
    chk("sp_after_underflow", {24'd0, sp}, 32'h48);

    expect_txn(1'b1, 1'b0, 16'h0000, 2);
    drive(1'b1, 1'b0, 2'd0, 16'h1234);
    expect_txn(1'b0, 1'b1, 16'h0000, 2);
    drive(1'b0, 1'b1, 2'd3, 16'h0000);
    chk("sp_after_len0_len3", {24'd0, sp}, 32'h48);

    set_sp(8'h09);
    expect_txn(1'b0, 1'b1, 16'h0000, 2);
    drive(1'b0, 1'b0, 2'd2, 16'h1234);
    chk("sp_after_overflow", {24'd0, sp}, 32'h09);
    expect_txn(1'b0, 1'b0, 16'h0000, 3);
    exp_push.push_back(8'h5A);
    drive(1'b0, 1'b0, 2'd1, 16'h005A);
    chk("sp_at_limit", {24'd0, sp}, 32'h08);

    expect_txn(1'b1, 1'b0, 16'h005A, 4);
    exp_pops += 1;
    drive(1'b1, 1'b1, 2'd1, 16'h0000);
    chk("sp_after_pop1", {24'd0, sp}, 32'h09);

    // Port 1 was served last: round robin favours port 0, fixed priority port 1.
`ifdef STACK_SEQ_ROUND_ROBIN_EN
    w = 1'b0;
`else
    w = 1'b1;
`endif
    set_sp(8'h40);
    expect_txn(w, 1'b0, 16'h0000, 3);
    expect_txn(~w, 1'b0, 16'h0000, 3);
    exp_push.push_back(tie_data(w)); exp_push.push_back(tie_data(~w));
    fork
      drive(1'b0, 1'b0, 2'd1, 16'h0011);
      drive(1'b1, 1'b0, 2'd1, 16'h0022);
    join
    chk("sp_after_tie_push", {24'd0, sp}, 32'h3E);

    expect_txn(w, 1'b0, {8'h00, tie_data(~w)}, 4);
    expect_txn(~w, 1'b0, {8'h00, tie_data(w)}, 4);
    exp_pops += 2;
    fork
      drive(1'b0, 1'b1, 2'd1, 16'h0000);
      drive(1'b1, 1'b1, 2'd1, 16'h0000);
    join
    chk("sp_after_tie_pop", {24'd0, sp}, 32'h40);

    // Reset while the second byte of a push is on the strobe.
    set_sp(8'h30);
    exp_push.push_back(8'hA1);
    op0 = 1'b0; len0 = 2'd2; wdata0 = 16'hA1B2; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = stk_push_en;
    end
    chk("push_started", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    #1;
    chk("midreset_outputs", {done0, err0, done1, err1, busy, grant_id, stk_push_en, stk_pop_en,
        stk_push_data, rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_hold", {done0, err0, done1, err1, busy, grant_id, stk_push_en, stk_pop_en,
        stk_push_data, rdata}, 32'd0);
    chk("sp_after_abort", {24'd0, sp}, 32'h2F);
    rst = 1'b0;

    expect_txn(1'b0, 1'b0, 16'h0000, 3);
    exp_push.push_back(8'h77);
    drive(1'b0, 1'b0, 2'd1, 16'h0077);
    chk("sp_post_reset", {24'd0, sp}, 32'h2E);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    chk("push_queue_drained", exp_push.size(), 32'd0);
    chk("pops_drained", exp_pops, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
